gate_tt_sequencer: RTL and testbench

//  Self-checking truth-table driver for the 2-input NAND/NOR gate stage.

---
 rtl/gate_tt_sequencer_pkg.sv | 20 ++
 rtl/gate_tt_sequencer_dwell_timer.sv | 45 ++++
 rtl/gate_tt_sequencer.sv | 175 +++++++++++++++++
 tb/tb_gate_tt_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tt_sequencer_pkg.sv
// Shared definitions for the NAND/NOR truth-table sequencer.
//   state_e       : sequencer FSM states
//   NVEC          : number of input vectors in the truth table
//   exp_nand_nor  : golden {NAND, NOR} response for a given {a,b}
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NVEC = 4;

  // Golden gate response: bit 1 is the NAND output, bit 0 the NOR output.
  function automatic logic [1:0] exp_nand_nor(input logic a, input logic b);
    return {~(a & b), ~(a | b)};
  endfunction

endpackage

// File: rtl/gate_tt_sequencer_dwell_timer.sv
// Dwell counter for the truth-table sequencer.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count enable
//   last       : high while the count equals DWELL-1 (the sample cycle)
module dwell_timer #(
  parameter int DWELL = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CNT_W = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority so a new vector always starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Self-checking truth-table driver for a 2-input NAND/NOR gate stage.
// Steps {a,b} through 00,01,10,11, holding each vector DWELL cycles, and
// compares the gate outputs against the golden response in the last cycle
// of every dwell.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : run request, honoured only in IDLE or DONE
//   a, b         : registered gate inputs
//   t0_in, t1_in : gate NAND / NOR outputs under test
//   busy         : high while vectors are being applied
//   done, pass   : run finished / finished with no mismatches
//   err_vec      : bit i set if vector {a,b}=i mismatched
//   err_cnt      : number of failing vectors (popcount of err_vec)
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int DWELL = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       t0_in,
  input  logic       t1_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec,
  output logic [2:0] err_cnt
);

  if ((DWELL < 2) || (DWELL > 255)) begin : g_bad_dwell
    $error("gate_tt_sequencer: DWELL must be in 2..255");
  end

  localparam logic [1:0] VEC_LAST = 2'(NVEC - 1);

  state_e     state_q,   state_d;
  logic [1:0] vec_q,     vec_d;
  logic       a_q,       a_d;
  logic       b_q,       b_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       pass_q,    pass_d;
  logic [3:0] err_vec_q, err_vec_d;
  logic [2:0] err_cnt_q, err_cnt_d;

  logic       tmr_clr_s;
  logic       tmr_en_s;
  logic       tmr_last_s;
  logic       mismatch_s;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr_s),
    .en    (tmr_en_s),
    .last  (tmr_last_s)
  );

  // The gate is judged on the vector currently driven, i.e. the registered a/b.
  assign mismatch_s = ({t0_in, t1_in} != exp_nand_nor(a_q, b_q));

  // Next-state, vector stepping and error bookkeeping.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    a_d       = a_q;
    b_d       = b_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_vec_d = err_vec_q;
    err_cnt_d = err_cnt_q;
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // Timer stays parked at zero so the first dwell is full length.
        tmr_clr_s = 1'b1;
        if (start) begin
          state_d   = APPLY;
          vec_d     = 2'd0;
          a_d       = 1'b0;
          b_d       = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_vec_d = 4'b0000;
          err_cnt_d = 3'd0;
        end else begin
          state_d = state_q;
        end
      end

      APPLY: begin
        if (tmr_last_s) begin
          tmr_clr_s = 1'b1;
          if (mismatch_s) begin
            err_vec_d[vec_q] = 1'b1;
            if (err_cnt_q < 3'd4) begin
              err_cnt_d = err_cnt_q + 3'd1;
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end else begin
            err_vec_d = err_vec_q;
          end
          if (vec_q == VEC_LAST) begin
            // a/b deliberately keep 2'b11 while sitting in DONE.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_vec_d == 4'b0000);
          end else begin
            vec_d      = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
          end
        end else begin
          tmr_en_s = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        vec_d     = 2'd0;
        a_d       = 1'b0;
        b_d       = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        err_vec_d = 4'b0000;
        err_cnt_d = 3'd0;
        tmr_clr_s = 1'b1;
      end
    endcase
  end

  // State, vector and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= 2'd0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_vec_q <= 4'b0000;
      err_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_vec_q <= err_vec_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_vec = err_vec_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench for gate_tt_sequencer with DWELL=4.
module tb_gate_tt_sequencer;

  localparam int DWELL = 4;

  typedef struct {
    logic [1:0] ab;
    int         edge_n;
  } vec_exp_t;

  typedef struct {
    logic [3:0] ev;
    logic [2:0] ec;
    logic       ps;
    int         edge_n;
  } res_exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a, b, t0_in, t1_in, busy, done, pass;
  logic [3:0] err_vec;
  logic [2:0] err_cnt;

  int mode = 0;  // 0 good gate, 1 t0 stuck-at-1, 2 t0/t1 swapped
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  vec_exp_t sb_vec[$];
  res_exp_t sb_res[$];

  gate_tt_sequencer #(.DWELL(DWELL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .t0_in   (t0_in),
    .t1_in   (t1_in),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_vec (err_vec),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gate model under test, with injectable faults.
  always_comb begin
    t0_in = ~(a & b);
    t1_in = ~(a | b);
    if (mode == 1) begin
      t0_in = 1'b1;
    end else if (mode == 2) begin
      t0_in = ~(a | b);
      t1_in = ~(a & b);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a new vector or a result.
  logic       busy_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic [1:0] ab_prev = 2'b00;
  always @(posedge clk) begin
    vec_exp_t ve;
    res_exp_t re;
    #1;
    if (rst_n) begin
      if (busy && (!busy_prev || ({a, b} != ab_prev))) begin
        if (sb_vec.size() == 0) begin
          chk("vec_unexpected", {a, b}, -1);
        end else begin
          ve = sb_vec.pop_front();
          chk("vec_ab", {a, b}, ve.ab);
          chk("vec_edge", cyc, ve.edge_n);
        end
      end
      if (done && !done_prev) begin
        if (sb_res.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          re = sb_res.pop_front();
          chk("res_err_vec", err_vec, re.ev);
          chk("res_err_cnt", err_cnt, re.ec);
          chk("res_pass", pass, re.ps);
          chk("res_ab_hold", {a, b}, 3);
          chk("res_edge", cyc, re.edge_n);
        end
      end
    end
    busy_prev = busy;
    done_prev = done;
    ab_prev   = {a, b};
  end

  // Issue start for `hold` cycles and push the expected run into the scoreboard.
  task automatic start_run(input logic [3:0] ev, input logic [2:0] ec,
                           input logic ps, input int hold);
    int k;
    vec_exp_t ve;
    res_exp_t re;
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      ve.ab = 2'(i);
      ve.edge_n = k + i * DWELL;
      sb_vec.push_back(ve);
    end
    re.ev = ev; re.ec = ec; re.ps = ps; re.edge_n = k + 4 * DWELL;
    sb_res.push_back(re);
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while ((sb_res.size() != 0) && (n < 8 * DWELL + 10)) begin
      @(negedge clk);
      n++;
    end
    if (sb_res.size() != 0) begin
      chk({name, "_timeout"}, sb_res.size(), 0);
      sb_res.delete();
      sb_vec.delete();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ab", {a, b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_vec", err_vec, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // 1: good gate
    mode = 0;
    start_run(4'b0000, 3'd0, 1'b1, 1);
    wait_result("t1");

    // 2: t0 stuck-at-1 fails only on {a,b}=11
    mode = 1;
    start_run(4'b1000, 3'd1, 1'b0, 1);
    wait_result("t2");

    // 3: swapped outputs fail on 01 and 10
    mode = 2;
    start_run(4'b0110, 3'd2, 1'b0, 1);
    wait_result("t3");

    // 6: restart from DONE with a good gate clears the errors
    mode = 0;
    start_run(4'b0000, 3'd0, 1'b1, 1);
    chk("restart_err_vec", err_vec, 0);
    chk("restart_err_cnt", err_cnt, 0);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    wait_result("t6");

    // 4: reset in the middle of vector 2 after vector 1 already failed
    mode = 2;
    start_run(4'b0110, 3'd2, 1'b0, 1);
    begin
      int n;
      n = 0;
      while (!({a, b} == 2'b10 && busy) && n < 4 * DWELL + 4) begin
        @(negedge clk);
        n++;
      end
      chk("t4_reached_vec2", {a, b}, 2);
      chk("t4_err_before_rst", err_vec, 4'b0010);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ab", {a, b}, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_err_vec", err_vec, 0);
    chk("t4_rst_err_cnt", err_cnt, 0);
    chk("t4_rst_done", done, 0);
    sb_vec.delete();
    sb_res.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    start_run(4'b0000, 3'd0, 1'b1, 1);
    wait_result("t4_rerun");

    // 5: start held 3 cycles, then pulsed mid-run: exactly one run
    @(negedge clk);
    @(negedge clk);
    start_run(4'b0000, 3'd0, 1'b1, 3);
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("t5");
    repeat (3 * DWELL) @(negedge clk);
    chk("t5_done_held", done, 1);
    chk("t5_busy_low", busy, 0);
    chk("t5_pass_held", pass, 1);

    chk("sb_vec_empty", sb_vec.size(), 0);
    chk("sb_res_empty", sb_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
